// File: rtl/code_nco_slew_pkg.sv
// ============================================================================
// code_nco_slew_pkg : shared channel widths, code constants and clog2 helper
// Rev 1.0
// ============================================================================
`default_nettype none

package code_nco_slew_pkg;

  localparam int ACC_W_DEF    = 29;
  localparam int FCW_W_DEF    = 28;
  localparam int PHASE_W_DEF  = 10;
  localparam int SLEW_W_DEF   = 11;
  localparam int CHIPS_GPS_CA = 1023;

  // Nominal 2.046 MHz half-chip rate from a 40 MHz clock
  localparam logic [27:0] CODE_FCW_1023K = 28'h1A30552;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/code_nco_slew_hc_counter.sv
// ============================================================================
// code_nco_slew_hc_counter : modulo event counter with wrap (epoch) strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module code_nco_slew_hc_counter #(
  parameter int MODULUS = 2046,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  // Wrap is flagged in the same cycle as the increment that rolls over
  assign wrap = inc & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/code_nco_slew.sv
// ============================================================================
// code_nco_slew : code NCO with buffered frequency word, half-chip slewing,
//                 half-chip/epoch counter and TIC latching.  Rev 1.0
// ============================================================================
`default_nettype none

module code_nco_slew
  import code_nco_slew_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FCW_W     = FCW_W_DEF,
  parameter int PHASE_W   = PHASE_W_DEF,
  parameter int SLEW_W    = SLEW_W_DEF,
  parameter int CHIPS     = CHIPS_GPS_CA,
  parameter int SYNC_LOAD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tic_enable,
  input  logic                          f_wr,
  input  logic [FCW_W-1:0]              f_control,
  input  logic                          slew_req,
  input  logic [SLEW_W-1:0]             slew_halfchips,
  output logic                          slew_busy,
  output logic                          hc_enable,
  output logic                          epoch,
  output logic [PHASE_W-1:0]            code_nco_phase,
  output logic [clog2(2*CHIPS)-1:0]     hc_count_latched
);

  localparam int HC_W = clog2(2 * CHIPS);

  logic [ACC_W-1:0]  accum;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic [FCW_W-1:0]  f_pend;
  logic [FCW_W-1:0]  f_active;
  logic [SLEW_W-1:0] slew_cnt;
  logic [HC_W-1:0]   hc_cnt;

  assign sum       = {1'b0, accum} + {{(ACC_W + 1 - FCW_W){1'b0}}, f_active};
  assign carry     = sum[ACC_W];
  assign slew_busy = |slew_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      accum            <= '0;
      f_pend           <= '0;
      slew_cnt         <= '0;
      hc_enable        <= 1'b0;
      code_nco_phase   <= '0;
      hc_count_latched <= '0;
    end else begin
      accum     <= sum[ACC_W-1:0];
      hc_enable <= carry & ~slew_busy;
      if (f_wr) begin
        f_pend <= f_control;
      end
      // Acceptance uses the idle count, so a carry in that cycle still emits
      if (slew_busy) begin
        if (carry) begin
          slew_cnt <= slew_cnt - 1'b1;
        end
      end else if (slew_req && (slew_halfchips != '0)) begin
        slew_cnt <= slew_halfchips;
      end
      if (tic_enable) begin
        code_nco_phase   <= accum[ACC_W-1 -: PHASE_W];
        hc_count_latched <= hc_cnt;
      end
    end
  end

  generate
    if (SYNC_LOAD != 0) begin : g_sync_load
      always_ff @(posedge clk) begin
        if (rst) begin
          f_active <= '0;
        end else if (tic_enable) begin
          f_active <= f_pend;
        end
      end
    end else begin : g_async_load
      always_ff @(posedge clk) begin
        if (rst) begin
          f_active <= '0;
        end else begin
          f_active <= f_pend;
        end
      end
    end
  endgenerate

  code_nco_slew_hc_counter #(
    .MODULUS (2 * CHIPS),
    .CNT_W   (HC_W)
  ) u_hc_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (hc_enable),
    .cnt  (hc_cnt),
    .wrap (epoch)
  );

endmodule

`default_nettype wire

// File: tb/tb_code_nco_slew.sv
// ============================================================================
// tb_code_nco_slew : two DUTs (immediate and TIC-synchronous load) checked
//                    against a cycle-level arithmetic reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_code_nco_slew;

  localparam int    CHIPS   = 4;
  localparam int    HC_MOD  = 2 * CHIPS;
  localparam longint ACC_MOD = 64'd1 << 29;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tic_enable = 1'b0;
  logic        f_wr = 1'b0;
  logic [27:0] f_control = '0;
  logic        slew_req = 1'b0;
  logic [10:0] slew_halfchips = '0;

  logic       bz0, hc0, ep0, bz1, hc1, ep1;
  logic [9:0] ph0, ph1;
  logic [2:0] hl0, hl1;

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = immediate load, 1 = TIC-synchronous load
  longint m_acc [2];
  int     m_fpend [2], m_fact [2], m_slew [2], m_hc [2], m_phase [2], m_hclat [2];
  bit     m_hcen [2];

  always #5 clk = ~clk;

  code_nco_slew #(.ACC_W(29), .FCW_W(28), .PHASE_W(10), .SLEW_W(11),
                  .CHIPS(CHIPS), .SYNC_LOAD(0)) dut0 (
    .clk(clk), .rst(rst), .tic_enable(tic_enable), .f_wr(f_wr),
    .f_control(f_control), .slew_req(slew_req), .slew_halfchips(slew_halfchips),
    .slew_busy(bz0), .hc_enable(hc0), .epoch(ep0),
    .code_nco_phase(ph0), .hc_count_latched(hl0));

  code_nco_slew #(.ACC_W(29), .FCW_W(28), .PHASE_W(10), .SLEW_W(11),
                  .CHIPS(CHIPS), .SYNC_LOAD(1)) dut1 (
    .clk(clk), .rst(rst), .tic_enable(tic_enable), .f_wr(f_wr),
    .f_control(f_control), .slew_req(slew_req), .slew_halfchips(slew_halfchips),
    .slew_busy(bz1), .hc_enable(hc1), .epoch(ep1),
    .code_nco_phase(ph1), .hc_count_latched(hl1));

  function automatic logic [15:0] act(input int k);
    return (k == 0) ? {hc0, ep0, bz0, ph0, hl0} : {hc1, ep1, bz1, ph1, hl1};
  endfunction

  function automatic logic [15:0] exp_v(input int k);
    logic ep;
    ep = m_hcen[k] && (m_hc[k] == HC_MOD - 1);
    return {m_hcen[k], ep, (m_slew[k] > 0), 10'(m_phase[k]), 3'(m_hclat[k])};
  endfunction

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      longint s;
      bit     c;
      int     nfact;
      if (rst) begin
        m_acc[k] = 0; m_fpend[k] = 0; m_fact[k] = 0; m_slew[k] = 0;
        m_hc[k] = 0; m_phase[k] = 0; m_hclat[k] = 0; m_hcen[k] = 0;
      end else begin
        s = m_acc[k] + longint'(m_fact[k]);
        c = (s >= ACC_MOD);
        nfact = (k == 1) ? (tic_enable ? m_fpend[k] : m_fact[k]) : m_fpend[k];
        if (tic_enable) begin
          m_phase[k] = int'(m_acc[k] >> 19);
          m_hclat[k] = m_hc[k];
        end
        if (m_hcen[k]) m_hc[k] = (m_hc[k] + 1) % HC_MOD;
        m_hcen[k] = c && (m_slew[k] == 0);
        if (m_slew[k] > 0) begin
          if (c) m_slew[k] = m_slew[k] - 1;
        end else if (slew_req && slew_halfchips != 0) begin
          m_slew[k] = int'(slew_halfchips);
        end
        m_fact[k] = nfact;
        if (f_wr) m_fpend[k] = int'(f_control);
        m_acc[k] = s % ACC_MOD;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (act(k) !== 16'h0000 || exp_v(k) !== 16'h0000) begin
        fails++;
        $display("FAIL reset dut%0d: got %h expected 0000", k, act(k));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rate();
    int pulses = 0, epochs = 0, last = -1;
    f_control = 28'h8000000; f_wr = 1'b1; tick();
    f_wr = 1'b0; tic_enable = 1'b1; tick();
    tic_enable = 1'b0;
    for (int i = 0; i < 410; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (act(k) !== exp_v(k)) begin
          fails++;
          $display("FAIL rate dut%0d cyc %0d: got %h expected %h", k, i, act(k), exp_v(k));
        end
      end
      if (i >= 10 && hc0) begin
        pulses++;
        if (ep0) epochs++;
        if (last >= 0) begin
          tests++;
          if (i - last != 4) begin
            fails++;
            $display("FAIL rate_gap: got %0d expected 4", i - last);
          end
        end
        last = i;
      end
    end
    tests++;
    if (pulses != 100) begin
      fails++;
      $display("FAIL rate_count: got %0d expected 100", pulses);
    end
    tests++;
    if (epochs < 12 || epochs > 13) begin
      fails++;
      $display("FAIL epoch_count: got %0d expected 12..13", epochs);
    end
  endtask

  task automatic test_tic();
    for (int i = 0; i < 64; i++) begin
      tic_enable = 1'($urandom_range(0, 1));
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (act(k) !== exp_v(k)) begin
          fails++;
          $display("FAIL tic dut%0d cyc %0d: got %h expected %h", k, i, act(k), exp_v(k));
        end
      end
    end
    tic_enable = 1'b0;
  endtask

  task automatic test_slew();
    int busy_cnt;
    for (int i = 0; i < 8; i++) begin
      if (m_acc[0] + m_fact[0] >= ACC_MOD) break;
      tick();
    end
    slew_req = 1'b1; slew_halfchips = 11'd3;
    tick();
    slew_req = 1'b0;
    busy_cnt = int'(bz0);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin slew_req = 1'b1; slew_halfchips = 11'd5; end
      tick();
      slew_req = 1'b0;
      busy_cnt += int'(bz0);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (act(k) !== exp_v(k)) begin
          fails++;
          $display("FAIL slew dut%0d cyc %0d: got %h expected %h", k, i, act(k), exp_v(k));
        end
      end
    end
    tests++;
    if (busy_cnt != 12) begin
      fails++;
      $display("FAIL slew_busy_len: got %0d expected 12", busy_cnt);
    end
  endtask

  task automatic test_sync_load();
    int last = -1;
    f_control = 28'h4000000; f_wr = 1'b1; tick();
    f_wr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tic_enable = (i == 19);
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (act(k) !== exp_v(k)) begin
          fails++;
          $display("FAIL sync_load dut%0d cyc %0d: got %h expected %h", k, i, act(k), exp_v(k));
        end
      end
      if (hc1 && (i < 19 || i > 32)) begin
        if (last >= 0) begin
          tests++;
          if (i - last != ((i < 19) ? 4 : 8)) begin
            fails++;
            $display("FAIL sync_gap: got %0d at cyc %0d", i - last, i);
          end
        end
        last = i;
      end else if (i == 19) begin
        last = -1;
      end
    end
    tic_enable = 1'b0;
  endtask

  task automatic test_reset_mid_slew();
    int pulses = 0;
    bit hit = 0;
    f_control = 28'h8000000; f_wr = 1'b1; tick();
    f_wr = 1'b0; tic_enable = 1'b1; tick();
    tic_enable = 1'b0;
    slew_req = 1'b1; slew_halfchips = 11'd5; tick();
    slew_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_slew[0] == 2) begin hit = 1; break; end
      tick();
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_slew_wait: slew count 2 not reached, got %0d", m_slew[0]);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (act(k) !== 16'h0000) begin
        fails++;
        $display("FAIL mid_slew_reset dut%0d: got %h expected 0000", k, act(k));
      end
    end
    f_wr = 1'b1; tick();
    f_wr = 1'b0; tic_enable = 1'b1; tick();
    tic_enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i >= 20 && hc0) pulses++;
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (act(k) !== exp_v(k)) begin
          fails++;
          $display("FAIL post_reset dut%0d cyc %0d: got %h expected %h", k, i, act(k), exp_v(k));
        end
      end
    end
    tests++;
    if (pulses != 5) begin
      fails++;
      $display("FAIL post_reset_rate: got %0d expected 5", pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      f_wr       = ($urandom_range(0, 15) == 0);
      f_control  = 28'($urandom_range(0, 32'h0FFF_FFFF));
      tic_enable = ($urandom_range(0, 7) == 0);
      slew_req   = ($urandom_range(0, 7) == 0);
      slew_halfchips = 11'($urandom_range(0, 7));
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (act(k) !== exp_v(k)) begin
          fails++;
          $display("FAIL random dut%0d cyc %0d: got %h expected %h", k, i, act(k), exp_v(k));
        end
      end
    end
    rst = 1'b0; f_wr = 1'b0; tic_enable = 1'b0; slew_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rate();
    test_tic();
    test_slew();
    test_sync_load();
    test_reset_mid_slew();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
